// File: rtl/opendap_ap_router_pkg.sv
`default_nettype none
// ============================================================================
// Package   : opendap_ap_router_pkg
// Purpose   : Shared constants and helpers for the AP router: bus widths,
//             FSM state encoding and the timeout counter width function.
// Revision  : 1.0  initial release
// ============================================================================
package opendap_ap_router_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 6;
    localparam int c_SEL_W  = 8;

    // Router FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Counter must hold values 0..timeout so it can saturate at timeout;
    // never narrower than one bit so the disabled case still elaborates.
    function automatic int f_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage : opendap_ap_router_pkg
`default_nettype wire

// File: rtl/opendap_ap_router_timeout.sv
`default_nettype none
// ============================================================================
// Module    : opendap_ap_router_timeout
// Purpose   : Bus-hang watchdog for the AP router. Cleared on load, counts
//             up while enabled, saturates at TIMEOUT and flags expiry when
//             the count equals TIMEOUT-1 (the TIMEOUT-th enabled cycle).
// Ports     : swclk    - clock
//             rst_n    - asynchronous active-low reset
//             i_load   - clear the count (new access accepted)
//             i_en     - increment (BUSY cycle without ready)
//             o_expire - current cycle is the last allowed BUSY cycle
// Revision  : 1.0  initial release
// ============================================================================
module opendap_ap_router_timeout #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic swclk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == c_LAST);

endmodule : opendap_ap_router_timeout
`default_nettype wire

// File: rtl/opendap_ap_router.sv
`default_nettype none
// ============================================================================
// Module    : opendap_ap_router
// Purpose   : Routes the SW-DP AP access port to N_APS downstream APs by
//             APSEL. Each access is sequenced IDLE -> BUSY -> DONE and the
//             response is registered. Unmapped APSEL is RAZ/WI, a hung AP is
//             aborted after TIMEOUT BUSY cycles, DAPABORT is fanned out.
// Ports     : swclk/rst_n            - clock, async active-low reset
//             up_sel/up_addr/up_wdata - upstream request
//             up_wen/up_ren/up_abort - upstream strobes and DAPABORT
//             up_rdata/up_rdy/up_err - registered upstream response
//             dn_addr/dn_wdata       - broadcast request fields
//             dn_wen/dn_ren/dn_abort - per-AP strobes
//             dn_rdata/dn_rdy/dn_err - per-AP responses (rdata packed)
// Revision  : 1.0  initial release
// ============================================================================
module opendap_ap_router
    import opendap_ap_router_pkg::*;
#(
    parameter int N_APS   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    swclk,
    input  logic                    rst_n,
    input  logic [c_SEL_W-1:0]      up_sel,
    input  logic [c_ADDR_W-1:0]     up_addr,
    input  logic [c_DATA_W-1:0]     up_wdata,
    input  logic                    up_wen,
    input  logic                    up_ren,
    input  logic                    up_abort,
    output logic [c_DATA_W-1:0]     up_rdata,
    output logic                    up_rdy,
    output logic                    up_err,
    output logic [c_ADDR_W-1:0]     dn_addr,
    output logic [c_DATA_W-1:0]     dn_wdata,
    output logic [N_APS-1:0]        dn_wen,
    output logic [N_APS-1:0]        dn_ren,
    output logic [N_APS-1:0]        dn_abort,
    input  logic [32*N_APS-1:0]     dn_rdata,
    input  logic [N_APS-1:0]        dn_rdy,
    input  logic [N_APS-1:0]        dn_err
);

    localparam int c_AP_W  = (N_APS > 1) ? $clog2(N_APS) : 1;
    localparam int c_CNT_W = f_cnt_width(TIMEOUT);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_AP_W-1:0]   r_cur_ap;
    logic                r_is_read;
    logic [c_DATA_W-1:0] r_rdata;
    logic                r_err;

    logic                w_strobe;
    logic                w_mapped;
    logic                w_busy;
    logic                w_start;
    logic                w_start_map;
    logic                w_start_unmap;
    logic                w_cur_rdy;
    logic                w_cur_err;
    logic                w_complete;
    logic                w_timeout;
    logic                w_count_en;
    logic                w_expire;
    logic [N_APS-1:0]    w_sel_onehot;
    logic [N_APS-1:0]    w_cur_onehot;
    logic [c_DATA_W-1:0] w_sel_rdata;

    // ------------------------------------------------------------------
    // Request qualification. Abort pre-empts everything; a strobe during
    // BUSY is a protocol violation and is dropped.
    // ------------------------------------------------------------------
    assign w_strobe      = up_wen | up_ren;
    assign w_mapped      = (up_sel < c_SEL_W'(N_APS));
    assign w_busy        = (r_state == c_ST_BUSY);
    assign w_start       = w_strobe & ~up_abort & ~w_busy;
    assign w_start_map   = w_start & w_mapped;
    assign w_start_unmap = w_start & ~w_mapped;

    assign w_cur_rdy  = dn_rdy[r_cur_ap];
    assign w_cur_err  = dn_err[r_cur_ap];
    // Ready wins over expiry when both occur in the same BUSY cycle.
    assign w_complete = w_busy & ~up_abort & w_cur_rdy;
    assign w_timeout  = w_busy & ~up_abort & ~w_cur_rdy & w_expire;
    assign w_count_en = w_busy & ~w_cur_rdy;

    // APSEL and current-AP decode; dn_rdata slice of the latched AP
    always_comb begin
        w_sel_onehot = '0;
        w_cur_onehot = '0;
        w_sel_rdata  = '0;
        for (int i = 0; i < N_APS; i++) begin
            w_sel_onehot[i] = (up_sel == c_SEL_W'(i));
            w_cur_onehot[i] = (r_cur_ap == c_AP_W'(i));
            if (r_cur_ap == c_AP_W'(i)) begin
                w_sel_rdata = dn_rdata[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus-hang watchdog
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT != 0) begin : g_timeout
            opendap_ap_router_timeout #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (c_CNT_W)
            ) u_timeout (
                .swclk    (swclk),
                .rst_n    (rst_n),
                .i_load   (w_start_map),
                .i_en     (w_count_en),
                .o_expire (w_expire)
            );
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state. DONE accepts a new strobe exactly like IDLE.
    always_comb begin
        w_next_state = r_state;
        if (up_abort) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_start_map) begin
                        w_next_state = c_ST_BUSY;
                    end else if (w_start_unmap) begin
                        w_next_state = c_ST_DONE;
                    end else begin
                        w_next_state = c_ST_IDLE;
                    end
                end
                c_ST_BUSY: begin
                    if (w_complete || w_timeout) begin
                        w_next_state = c_ST_DONE;
                    end
                end
                default: w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        dn_wen   = '0;
        dn_ren   = '0;
        dn_abort = '0;
        if (w_start_map && up_wen) begin
            dn_wen = w_sel_onehot;
        end
        if (w_start_map && up_ren) begin
            dn_ren = w_sel_onehot;
        end
        if (up_abort) begin
            dn_abort = '1;
        end else if (w_timeout) begin
            dn_abort = w_cur_onehot;
        end
    end

    assign up_rdy   = (r_state != c_ST_BUSY);
    assign up_err   = r_err;
    assign up_rdata = r_rdata;
    assign dn_addr  = up_addr;
    assign dn_wdata = up_wdata;

    // ------------------------------------------------------------------
    // Response capture. r_err is only ever set on the way into DONE, so
    // it is a single-cycle pulse aligned with the DONE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cur_ap  <= '0;
            r_is_read <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_start_map) begin
                r_cur_ap  <= up_sel[c_AP_W-1:0];
                r_is_read <= up_ren;
            end else if (w_start_unmap) begin
                if (up_ren) begin
                    r_rdata <= '0;
                end
            end else if (w_complete) begin
                r_err <= w_cur_err;
                if (r_is_read) begin
                    r_rdata <= w_sel_rdata;
                end
            end else if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

endmodule : opendap_ap_router
`default_nettype wire

// File: tb/tb_opendap_ap_router.sv
`default_nettype none
// ============================================================================
// Module    : tb_opendap_ap_router
// Purpose   : Directed self-checking bench for opendap_ap_router with
//             N_APS=4 and TIMEOUT=8. Inputs change 1 time unit after the
//             rising edge; outputs are checked in the same window.
// Revision  : 1.0  initial release
// ============================================================================
module tb_opendap_ap_router;

    logic         swclk;
    logic         rst_n;
    logic [7:0]   up_sel;
    logic [5:0]   up_addr;
    logic [31:0]  up_wdata;
    logic         up_wen;
    logic         up_ren;
    logic         up_abort;
    logic [31:0]  up_rdata;
    logic         up_rdy;
    logic         up_err;
    logic [5:0]   dn_addr;
    logic [31:0]  dn_wdata;
    logic [3:0]   dn_wen;
    logic [3:0]   dn_ren;
    logic [3:0]   dn_abort;
    logic [127:0] dn_rdata;
    logic [3:0]   dn_rdy;
    logic [3:0]   dn_err;

    int checks     = 0;
    int failures   = 0;
    int proto_viol = 0;

    opendap_ap_router #(
        .N_APS   (4),
        .TIMEOUT (8)
    ) dut (
        .swclk    (swclk),
        .rst_n    (rst_n),
        .up_sel   (up_sel),
        .up_addr  (up_addr),
        .up_wdata (up_wdata),
        .up_wen   (up_wen),
        .up_ren   (up_ren),
        .up_abort (up_abort),
        .up_rdata (up_rdata),
        .up_rdy   (up_rdy),
        .up_err   (up_err),
        .dn_addr  (dn_addr),
        .dn_wdata (dn_wdata),
        .dn_wen   (dn_wen),
        .dn_ren   (dn_ren),
        .dn_abort (dn_abort),
        .dn_rdata (dn_rdata),
        .dn_rdy   (dn_rdy),
        .dn_err   (dn_err)
    );

    initial swclk = 1'b0;
    always #5 swclk = ~swclk;

    // Strobe while the router is BUSY (and not aborting) is illegal stimulus
    always @(negedge swclk) begin
        if (rst_n && (up_wen || up_ren) && !up_abort && !up_rdy) begin
            proto_viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge swclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        up_sel   = '0;
        up_addr  = '0;
        up_wdata = '0;
        up_wen   = 1'b0;
        up_ren   = 1'b0;
        up_abort = 1'b0;
        dn_rdata = '0;
        dn_rdy   = '0;
        dn_err   = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("reset_rdy",   32'(up_rdy),   32'h1);
        check("reset_err",   32'(up_err),   32'h0);
        check("reset_rdata", up_rdata,      32'h0);
        #3 rst_n = 1'b1;
        tick();

        // ---------------- read AP1, ready in first BUSY cycle ----------------
        up_sel = 8'd1; up_addr = 6'h0C; up_ren = 1'b1;       // T0
        #1;
        check("rd1_dn_ren",  32'(dn_ren),  32'h2);
        check("rd1_dn_wen",  32'(dn_wen),  32'h0);
        check("rd1_dn_addr", 32'(dn_addr), 32'h0C);
        tick();                                               // T1
        up_ren = 1'b0;
        check("rd1_rdy_T1", 32'(up_rdy), 32'h0);
        dn_rdy = 4'b0010;
        dn_rdata[31:0]  = 32'hDEADBEEF;
        dn_rdata[63:32] = 32'h12345678;
        tick();                                               // T2
        dn_rdy = 4'b0000;
        check("rd1_rdy_T2",   32'(up_rdy), 32'h1);
        check("rd1_err_T2",   32'(up_err), 32'h0);
        check("rd1_rdata_T2", up_rdata,    32'h12345678);
        tick();                                               // T3
        check("rd1_rdata_hold", up_rdata, 32'h12345678);

        // ---------------- write AP2, 5 wait cycles then error ----------------
        up_sel = 8'd2; up_wdata = 32'hCAFEF00D; up_wen = 1'b1; // T0
        #1;
        check("wr2_dn_wen",   32'(dn_wen), 32'h4);
        check("wr2_dn_ren",   32'(dn_ren), 32'h0);
        check("wr2_dn_wdata", dn_wdata,    32'hCAFEF00D);
        tick();                                               // T1
        up_wen = 1'b0;
        dn_rdy = 4'b1011;                 // other APs ready: must be ignored
        dn_err = 4'b1011;
        #1;
        check("wr2_dn_wen_T1", 32'(dn_wen), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            tick();                                           // T2..T5
            check("wr2_wait_rdy", 32'(up_rdy), 32'h0);
        end
        tick();                                               // T6
        dn_rdy = 4'b0100;
        dn_err = 4'b0100;
        dn_rdata[95:64] = 32'h55AA55AA;
        tick();                                               // T7
        dn_rdy = '0;
        dn_err = '0;
        check("wr2_rdy_done",   32'(up_rdy), 32'h1);
        check("wr2_err_done",   32'(up_err), 32'h1);
        check("wr2_rdata_kept", up_rdata,    32'h12345678);
        tick();                                               // T8
        check("wr2_err_1cyc",   32'(up_err), 32'h0);

        // ---------------- unmapped read, then strobe accepted in DONE --------
        up_sel = 8'h20; up_ren = 1'b1;                        // T0
        #1;
        check("unm_dn_ren", 32'(dn_ren), 32'h0);
        check("unm_dn_wen", 32'(dn_wen), 32'h0);
        tick();                                               // T1 = DONE
        check("unm_rdy",   32'(up_rdy), 32'h1);
        check("unm_err",   32'(up_err), 32'h0);
        check("unm_rdata", up_rdata,    32'h0);
        up_sel = 8'd3;                    // new read issued in the DONE cycle
        #1;
        check("done_accept_dn_ren", 32'(dn_ren), 32'h8);
        tick();
        up_ren = 1'b0;
        check("rd3_rdy_busy", 32'(up_rdy), 32'h0);
        dn_rdy = 4'b1000;
        dn_rdata[127:96] = 32'h0BADF00D;
        tick();
        dn_rdy = '0;
        check("rd3_rdata", up_rdata, 32'h0BADF00D);
        tick();

        // ---------------- timeout on AP0 ----------------
        up_sel = 8'd0; up_ren = 1'b1;                         // T0
        tick();                                               // T1
        up_ren = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            check("to_no_abort", 32'(dn_abort), 32'h0);
            check("to_busy_rdy", 32'(up_rdy),   32'h0);
            tick();                                           // T2..T8
        end
        #1;
        check("to_abort_T8", 32'(dn_abort), 32'h1);
        check("to_rdy_T8",   32'(up_rdy),   32'h0);
        tick();                                               // T9
        check("to_rdy_T9",   32'(up_rdy),   32'h1);
        check("to_err_T9",   32'(up_err),   32'h1);
        check("to_rdata_T9", up_rdata,      32'h0);
        check("to_abort_T9", 32'(dn_abort), 32'h0);
        tick();

        // ---------------- abort during BUSY with a stray strobe ----------------
        up_sel = 8'd1; up_ren = 1'b1;                         // T0
        tick();                                               // T1 BUSY
        up_ren = 1'b0;
        dn_rdata[63:32] = 32'h600DCAFE;
        up_abort = 1'b1; up_sel = 8'd2; up_wen = 1'b1;
        #1;
        check("ab_dn_abort", 32'(dn_abort), 32'hF);
        check("ab_dn_wen",   32'(dn_wen),   32'h0);
        check("ab_dn_ren",   32'(dn_ren),   32'h0);
        tick();
        up_abort = 1'b0; up_wen = 1'b0;
        #1;
        check("ab_rdy",      32'(up_rdy),   32'h1);
        check("ab_err",      32'(up_err),   32'h0);
        check("ab_rdata",    up_rdata,      32'h0);
        check("ab_abort_off", 32'(dn_abort), 32'h0);
        tick();

        // ---------------- reset mid-BUSY ----------------
        up_sel = 8'd1; up_ren = 1'b1;                         // complete a read
        tick();
        up_ren = 1'b0;
        dn_rdy = 4'b0010;
        tick();
        dn_rdy = '0;
        check("pre_rst_rdata", up_rdata, 32'h600DCAFE);
        up_sel = 8'd2; up_ren = 1'b1;                         // T0
        tick();                                               // T1 BUSY
        up_ren = 1'b0;
        check("rst_busy_rdy", 32'(up_rdy), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_rdy",   32'(up_rdy),   32'h1);
        check("rst_async_err",   32'(up_err),   32'h0);
        check("rst_async_rdata", up_rdata,      32'h0);
        check("rst_no_abort",    32'(dn_abort), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        up_sel = 8'd3; up_ren = 1'b1;                         // T0
        tick();                                               // T1
        up_ren = 1'b0;
        check("post_rst_busy", 32'(up_rdy), 32'h0);
        dn_rdy = 4'b1000;
        dn_rdata[127:96] = 32'h13572468;
        tick();                                               // T2
        dn_rdy = '0;
        check("post_rst_rdy",   32'(up_rdy), 32'h1);
        check("post_rst_err",   32'(up_err), 32'h0);
        check("post_rst_rdata", up_rdata,    32'h13572468);

        check("protocol_violations", 32'(proto_viol), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_opendap_ap_router
`default_nettype wire
